// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the set-associative block cache:
//   - state_t       : controller FSM state encoding
//   - addr_field()  : generic bit-field extraction used for tag/set/word/block
//   - victim_select : replacement choice (lowest invalid way, else RR pointer)
// No ports (package).
// -----------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FILL = 2'd3
    } state_t;

    // Upper bound on associativity the victim function can scan.
    localparam int MAX_WAYS = 64;

    // Extract 'width' bits starting at 'lsb'. Callers cast the result to the
    // field width, so one function serves every address field.
    function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                               input int          lsb,
                                               input int          width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (addr >> lsb) & mask;
    endfunction

    // Lowest-index invalid way wins; if every way is valid, use the pointer.
    function automatic int victim_select(input logic [63:0] valid,
                                         input int          n_ways,
                                         input int          ptr);
        int v;
        v = ptr;
        for (int i = MAX_WAYS - 1; i >= 0; i--) begin
            if (i < n_ways && !valid[i]) v = i;
        end
        return v;
    endfunction

endpackage

// File: rtl/cache_way_store.sv
// -----------------------------------------------------------------------------
// cache_way_store
// One way of the cache: block data array, tag array and per-set valid bits.
// Ports:
//   clk, rst       clock, synchronous active-high reset (clears valid bits)
//   i_clr          flush: clear all valid bits
//   i_lk_set/tag   lookup index and tag; o_hit is the combinational compare
//   i_lk_word      word within block for the registered read
//   i_rd_en        capture the addressed word into o_rd_word (held otherwise)
//   i_we           write block/tag and set valid at i_wr_set
//   i_wr_set/tag/block  write port fields
//   o_wr_valid     valid bit at i_wr_set (feeds victim selection)
// -----------------------------------------------------------------------------
module cache_way_store #(
    parameter int DWIDTH           = 32,
    parameter int SETS_BITS        = 5,
    parameter int BLOCK_WIDTH_BITS = 2,
    parameter int TAG_W            = 13
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_clr,
    input  logic [SETS_BITS-1:0]                      i_lk_set,
    input  logic [TAG_W-1:0]                          i_lk_tag,
    input  logic [BLOCK_WIDTH_BITS-1:0]               i_lk_word,
    input  logic                                      i_rd_en,
    output logic                                      o_hit,
    output logic [DWIDTH-1:0]                         o_rd_word,
    input  logic                                      i_we,
    input  logic [SETS_BITS-1:0]                      i_wr_set,
    input  logic [TAG_W-1:0]                          i_wr_tag,
    input  logic [DWIDTH*(2**BLOCK_WIDTH_BITS)-1:0]   i_wr_block,
    output logic                                      o_wr_valid
);

    localparam int SETS  = 1 << SETS_BITS;
    localparam int WORDS = 1 << BLOCK_WIDTH_BITS;

    logic [WORDS-1:0][DWIDTH-1:0] r_data [SETS];
    logic [TAG_W-1:0]             r_tag  [SETS];
    logic [SETS-1:0]              r_valid;
    logic [DWIDTH-1:0]            r_rd_word;

    // NOTE: data and tag arrays have no reset; the valid bits alone say whether
    // an entry means anything, which keeps the arrays mappable to block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_data[i_wr_set] <= i_wr_block;
            r_tag[i_wr_set]  <= i_wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_word <= '0;
        end else if (i_rd_en) begin
            r_rd_word <= r_data[i_lk_set][i_lk_word];
        end
    end

    // Flush and fill never coincide: flush applies in S_IDLE, fills in S_FILL.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_set] <= 1'b1;
        end
    end

    assign o_hit      = r_valid[i_lk_set] && (r_tag[i_lk_set] == i_lk_tag);
    assign o_rd_word  = r_rd_word;
    assign o_wr_valid = r_valid[i_wr_set];

endmodule

// File: rtl/cache_block_set_assoc.sv
// -----------------------------------------------------------------------------
// cache_block_set_assoc
// Read-only N-way set-associative block cache with round-robin replacement.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   addr_in_valid/addr_in      lookup request (word address)
//   addr_in_ready              request accepted (hit) this cycle
//   data_out_valid/data_out    word for the request accepted last cycle
//   addr_out_valid/addr_out    block fetch request (block address)
//   addr_out_ready             memory accepts the fetch
//   data_in_valid/data_in      block response
//   flush                      pulse: invalidate all lines
//   hit_count/miss_count       saturating statistics
// -----------------------------------------------------------------------------
module cache_block_set_assoc
    import cache_pkg::*;
#(
    parameter int DWIDTH           = 32,
    parameter int SETS_BITS        = 5,
    parameter int BLOCK_WIDTH_BITS = 2,
    parameter int WAYS_BITS        = 1,
    parameter int ADDR_IN_WIDTH    = 20,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     addr_in_valid,
    input  logic [ADDR_IN_WIDTH-1:0]                 addr_in,
    output logic                                     addr_in_ready,
    output logic                                     data_out_valid,
    output logic [DWIDTH-1:0]                        data_out,
    output logic                                     addr_out_valid,
    output logic [ADDR_IN_WIDTH-BLOCK_WIDTH_BITS-1:0] addr_out,
    input  logic                                     addr_out_ready,
    input  logic                                     data_in_valid,
    input  logic [DWIDTH*(2**BLOCK_WIDTH_BITS)-1:0]  data_in,
    input  logic                                     flush,
    output logic [CNT_WIDTH-1:0]                     hit_count,
    output logic [CNT_WIDTH-1:0]                     miss_count
);

    localparam int N_WAYS = 1 << WAYS_BITS;
    localparam int WAY_W  = (WAYS_BITS > 0) ? WAYS_BITS : 1;
    localparam int SETS   = 1 << SETS_BITS;
    localparam int TAG_W  = ADDR_IN_WIDTH - SETS_BITS - BLOCK_WIDTH_BITS;
    localparam int BLK_W  = ADDR_IN_WIDTH - BLOCK_WIDTH_BITS;

    state_t                                  r_state;
    logic [TAG_W-1:0]                        r_tag;
    logic [SETS_BITS-1:0]                    r_set;
    logic [BLK_W-1:0]                        r_blk_addr;
    logic [DWIDTH*(2**BLOCK_WIDTH_BITS)-1:0] r_block;
    logic [WAY_W-1:0]                        r_rr_ptr [SETS];
    logic                                    r_flush_pend;
    logic                                    r_data_valid;
    logic [WAY_W-1:0]                        r_hit_way;
    logic [CNT_WIDTH-1:0]                    r_hit_cnt;
    logic [CNT_WIDTH-1:0]                    r_miss_cnt;

    logic [TAG_W-1:0]            w_tag;
    logic [SETS_BITS-1:0]        w_set;
    logic [BLOCK_WIDTH_BITS-1:0] w_word;
    logic [BLK_W-1:0]            w_blk_addr;
    logic [N_WAYS-1:0]           w_hit_vec;
    logic [N_WAYS-1:0]           w_wr_valid;
    logic [DWIDTH-1:0]           w_rd_word [N_WAYS];
    logic                        w_hit;
    logic [WAY_W-1:0]            w_hit_way;
    logic [WAY_W-1:0]            w_victim;
    logic [WAY_W-1:0]            w_rr_next;
    logic                        w_flush_apply;
    logic                        w_accept;
    logic                        w_miss;
    logic                        w_fill;

    assign w_tag      = TAG_W'(addr_field(64'(addr_in), SETS_BITS + BLOCK_WIDTH_BITS, TAG_W));
    assign w_set      = SETS_BITS'(addr_field(64'(addr_in), BLOCK_WIDTH_BITS, SETS_BITS));
    assign w_word     = BLOCK_WIDTH_BITS'(addr_field(64'(addr_in), 0, BLOCK_WIDTH_BITS));
    assign w_blk_addr = BLK_W'(addr_field(64'(addr_in), BLOCK_WIDTH_BITS, BLK_W));

    // A pending flush blocks both hits and new misses until it is applied.
    assign w_flush_apply = (r_state == S_IDLE) && r_flush_pend;
    assign w_hit         = |w_hit_vec;
    assign w_accept      = (r_state == S_IDLE) && addr_in_valid &&  w_hit && !r_flush_pend && !flush;
    assign w_miss        = (r_state == S_IDLE) && addr_in_valid && !w_hit && !r_flush_pend && !flush;
    assign w_fill        = (r_state == S_FILL);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_hit_way = '0;
        for (int i = N_WAYS - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) w_hit_way = WAY_W'(i);
        end
    end

    assign w_victim  = WAY_W'(victim_select(64'(w_wr_valid), N_WAYS, int'(r_rr_ptr[r_set])));
    assign w_rr_next = WAY_W'((int'(w_victim) + 1) % N_WAYS);

    for (genvar g = 0; g < N_WAYS; g++) begin : g_way
        cache_way_store #(
            .DWIDTH           (DWIDTH),
            .SETS_BITS        (SETS_BITS),
            .BLOCK_WIDTH_BITS (BLOCK_WIDTH_BITS),
            .TAG_W            (TAG_W)
        ) u_way (
            .clk        (clk),
            .rst        (rst),
            .i_clr      (w_flush_apply),
            .i_lk_set   (w_set),
            .i_lk_tag   (w_tag),
            .i_lk_word  (w_word),
            .i_rd_en    (w_accept && w_hit_vec[g]),
            .o_hit      (w_hit_vec[g]),
            .o_rd_word  (w_rd_word[g]),
            .i_we       (w_fill && (w_victim == WAY_W'(g))),
            .i_wr_set   (r_set),
            .i_wr_tag   (r_tag),
            .i_wr_block (r_block),
            .o_wr_valid (w_wr_valid[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tag      <= '0;
            r_set      <= '0;
            r_blk_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_miss) begin
                    r_state    <= S_REQ;
                    r_tag      <= w_tag;
                    r_set      <= w_set;
                    r_blk_addr <= w_blk_addr;
                end
                S_REQ:  if (addr_out_ready) r_state <= S_WAIT;
                S_WAIT: if (data_in_valid) begin
                    r_state <= S_FILL;
                    r_block <= data_in;
                end
                S_FILL:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_flush_apply) begin
            for (int s = 0; s < SETS; s++) r_rr_ptr[s] <= '0;
        end else if (w_fill) begin
            r_rr_ptr[r_set] <= w_rr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_pend <= 1'b0;
            r_data_valid <= 1'b0;
            r_hit_way    <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            // A new flush pulse in the apply cycle re-arms the pending flag.
            r_flush_pend <= flush || (r_flush_pend && !w_flush_apply);
            r_data_valid <= w_accept;
            if (w_accept) r_hit_way <= w_hit_way;
            if (w_accept && r_hit_cnt != '1)  r_hit_cnt  <= r_hit_cnt + CNT_WIDTH'(1);
            if (w_miss && r_miss_cnt != '1)   r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
        end
    end

    assign addr_in_ready  = w_accept;
    assign data_out_valid = r_data_valid;
    // The selected way's read register only updates on its own hit, so data_out holds.
    assign data_out       = w_rd_word[r_hit_way];
    assign addr_out_valid = (r_state == S_REQ);
    assign addr_out       = r_blk_addr;
    assign hit_count      = r_hit_cnt;
    assign miss_count     = r_miss_cnt;

endmodule

// File: tb/tb_cache_block_set_assoc.sv
// -----------------------------------------------------------------------------
// tb_cache_block_set_assoc
// Directed bench for cache_block_set_assoc at default parameters. Memory
// blocks are generated so that word k of block b is {12'hC0D, b, k}, hence
// the expected word for any address a is {12'hC0D, a}.
// -----------------------------------------------------------------------------
module tb_cache_block_set_assoc;

    logic         clk = 1'b0;
    logic         rst;
    logic         addr_in_valid;
    logic [19:0]  addr_in;
    logic         addr_in_ready;
    logic         data_out_valid;
    logic [31:0]  data_out;
    logic         addr_out_valid;
    logic [17:0]  addr_out;
    logic         addr_out_ready;
    logic         data_in_valid;
    logic [127:0] data_in;
    logic         flush;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_block_set_assoc dut (
        .clk            (clk),
        .rst            (rst),
        .addr_in_valid  (addr_in_valid),
        .addr_in        (addr_in),
        .addr_in_ready  (addr_in_ready),
        .data_out_valid (data_out_valid),
        .data_out       (data_out),
        .addr_out_valid (addr_out_valid),
        .addr_out       (addr_out),
        .addr_out_ready (addr_out_ready),
        .data_in_valid  (data_in_valid),
        .data_in        (data_in),
        .flush          (flush),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [127:0] mk_block(input logic [17:0] blk);
        logic [127:0] b;
        logic [1:0]   k2;
        for (int k = 0; k < 4; k++) begin
            k2 = 2'(k);
            b[k*32 +: 32] = {12'hC0D, blk, k2};
        end
        return b;
    endfunction

    function automatic logic [31:0] exp_word(input logic [19:0] a);
        return {12'hC0D, a};
    endfunction

    // Full miss: memory ready at once, response r cycles after the request.
    task automatic fill_miss(input logic [19:0] a, input int r);
        addr_in        = a;
        addr_in_valid  = 1'b1;
        addr_out_ready = 1'b1;
        settle();
        chk("miss_not_ready", addr_in_ready, 0);
        tick();
        chk("req_valid", addr_out_valid, 1);
        chk("req_addr", addr_out, a >> 2);
        tick();
        for (int i = 1; i < r; i++) tick();
        data_in       = mk_block(a[19:2]);
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        settle();
        chk("fill_not_ready", addr_in_ready, 0);
        tick();
        chk("fill_ready", addr_in_ready, 1);
        tick();
        chk("fill_dvalid", data_out_valid, 1);
        chk("fill_data", data_out, exp_word(a));
        addr_in_valid = 1'b0;
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; addr_in_valid = 1'b0; addr_in = '0; addr_out_ready = 1'b0;
        data_in_valid = 1'b0; data_in = '0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        settle();
        chk("rst_ready", addr_in_ready, 0);
        chk("rst_dvalid", data_out_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_aovalid", addr_out_valid, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_misses", miss_count, 0);

        // Cold miss, response two cycles after the request.
        fill_miss(20'h00085, 2);
        chk("t1_hits", hit_count, 1);
        chk("t1_misses", miss_count, 1);

        // Streaming hits across the block.
        addr_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr_in = 20'h00084 + 20'(i);
            settle();
            chk("stream_ready", addr_in_ready, 1);
            tick();
            chk("stream_dvalid", data_out_valid, 1);
            chk("stream_data", data_out, exp_word(20'h00084 + 20'(i)));
        end
        addr_in_valid = 1'b0;
        settle();
        chk("t2_hits", hit_count, 5);

        // Flush in idle with a hitting request present.
        addr_in = 20'h00084; addr_in_valid = 1'b1; flush = 1'b1;
        settle();
        chk("flush_cycle_ready", addr_in_ready, 0);
        tick();
        flush = 1'b0;
        settle();
        chk("flush_apply_ready", addr_in_ready, 0);
        addr_in_valid = 1'b0;
        tick();
        chk("flush_hits", hit_count, 5);
        chk("flush_misses", miss_count, 1);

        // Conflict: two ways filled, third tag evicts way 0 by round-robin.
        fill_miss(20'h00004, 1);
        fill_miss(20'h00084, 1);
        fill_miss(20'h00104, 1);
        addr_in = 20'h00084; addr_in_valid = 1'b1;
        settle();
        chk("conf_hit_ready", addr_in_ready, 1);
        tick();
        chk("conf_hit_data", data_out, exp_word(20'h00084));
        addr_in_valid = 1'b0;
        fill_miss(20'h00004, 1);
        chk("t3_hits", hit_count, 10);
        chk("t3_misses", miss_count, 5);

        // Backpressure on the fetch port.
        addr_in = 20'h00200; addr_in_valid = 1'b1; addr_out_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_aovalid", addr_out_valid, 1);
            chk("bp_addr", addr_out, 18'h00080);
            chk("bp_ready", addr_in_ready, 0);
            tick();
        end
        addr_out_ready = 1'b1;
        settle();
        chk("bp_release", addr_out_valid, 1);
        tick();
        data_in = mk_block(18'h00080); data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        tick();
        chk("bp_fill_ready", addr_in_ready, 1);
        tick();
        chk("bp_data", data_out, exp_word(20'h00200));
        addr_in_valid = 1'b0;
        settle();

        // Flush while waiting for the response.
        addr_in = 20'h00300; addr_in_valid = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        data_in = mk_block(18'h000C0); data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        tick();
        chk("fw_apply_ready", addr_in_ready, 0);
        chk("fw_hits", hit_count, 11);
        chk("fw_misses", miss_count, 7);
        tick();
        fill_miss(20'h00300, 1);
        chk("t5_hits", hit_count, 12);
        chk("t5_misses", miss_count, 8);

        // Reset while waiting for the response.
        addr_in = 20'h00400; addr_in_valid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; addr_in_valid = 1'b0;
        settle();
        chk("mr_ready", addr_in_ready, 0);
        chk("mr_dvalid", data_out_valid, 0);
        chk("mr_data", data_out, 0);
        chk("mr_aovalid", addr_out_valid, 0);
        chk("mr_hits", hit_count, 0);
        chk("mr_misses", miss_count, 0);
        data_in = mk_block(18'h00100); data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        settle();
        chk("late_resp_aovalid", addr_out_valid, 0);
        fill_miss(20'h00400, 1);
        chk("t6_hits", hit_count, 1);
        chk("t6_misses", miss_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_block_set_assoc.md
# cache_block_set_assoc

Read-only, parametrised N-way set-associative block cache that sits between a basic block's memory requester and the shared memory port. It generalises the directly-mapped block cache with configurable associativity, round-robin replacement, an explicit fill-response handshake, a flush input and hit/miss counters. Hits return one word per cycle. Misses fetch a whole block over the outbound port, refill a victim way, then retry the lookup.

## Interface
Parameters:
- DWIDTH, 32, word width.
- SETS_BITS, 5, log2 of the number of sets.
- BLOCK_WIDTH_BITS, 2, log2 of words per block.
- WAYS_BITS, 1, log2 of associativity (0 gives direct-mapped).
- ADDR_IN_WIDTH, 20, word address width; must exceed SETS_BITS+BLOCK_WIDTH_BITS.
- CNT_WIDTH, 32, statistics counter width.

Ports:
- clk  in  1  single clock. Reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- addr_in_valid  in  1  lookup request.
- addr_in  in  ADDR_IN_WIDTH  word address: tag = top bits, set = [BLOCK_WIDTH_BITS+:SETS_BITS], word = [0+:BLOCK_WIDTH_BITS].
- addr_in_ready  out  1  request accepted (hit) this cycle.
- data_out_valid  out  1  data_out carries the word for the request accepted last cycle.
- data_out  out  DWIDTH  returned word.
- addr_out_valid  out  1  block fetch request.
- addr_out  out  ADDR_IN_WIDTH-BLOCK_WIDTH_BITS  block address (addr_in without word bits).
- addr_out_ready  in  1  memory accepts the fetch.
- data_in_valid  in  1  block response valid.
- data_in  in  DWIDTH*2**BLOCK_WIDTH_BITS  block; word k sits at [k*DWIDTH+:DWIDTH].
- flush  in  1  pulse: invalidate all lines.
- hit_count  out  CNT_WIDTH  accepted hits, saturating.
- miss_count  out  CNT_WIDTH  misses issued, saturating.

## Operation
- States: S_IDLE, S_REQ, S_WAIT, S_FILL.
- **S_IDLE**
  - hit = any way with valid && tag match in the indexed set.
  - addr_in_ready = addr_in_valid && hit && !flush_pend && !flush.
  - If addr_in_valid && !hit: latch the tag, set and block address; go to S_REQ; miss_count++.
- **S_REQ**
  - addr_out_valid = 1 and addr_out = latched block address, both held stable.
  - Go to S_WAIT on addr_out_ready.
- **S_WAIT**
  - Go to S_FILL on data_in_valid; register data_in.
- **S_FILL**
  - Write the block, tag and valid=1 into the victim way.
  - Return to S_IDLE.
  - The requester, still holding addr_in_valid, now hits.
- Victim selection: lowest-index invalid way; otherwise the per-set round-robin pointer. After every fill the pointer becomes filled_way+1, modulo the number of ways.
- Requester protocol: hold addr_in_valid and addr_in stable until addr_in_ready. If addr_in changes anyway, the outstanding fill still completes and the lookup is simply redone.
- **Flush**
  - Sampled in any state; sets flush_pend.
  - Applied in the first S_IDLE cycle: clears all valid bits and round-robin pointers.
  - No request is accepted in that cycle.
  - A fill in flight completes before the flush is applied.
  - The counters are not affected.
- Counters saturate at all-ones.

## Timing
- Hit latency: accept in cycle T, data_out_valid=1 at T+1. Back-to-back hits sustain 1 word/cycle.
- Miss (memory ready immediately, response R cycles after the request): ready at T+3+R from the first valid cycle. Data follows one cycle later.
- data_out holds its value when data_out_valid=0.
- Reset values:
  - All valid bits, round-robin pointers, flush_pend and counters = 0; state = S_IDLE.
  - Outputs: addr_in_ready=0, data_out_valid=0, data_out=0, addr_out_valid=0.
  - Reset mid-miss abandons the fetch; a late data_in_valid in S_IDLE is ignored.
- data_in_valid outside S_WAIT is ignored.

## Structure
- Shared package cache_pkg holds:
  - the state enum;
  - the victim-select function (first-invalid else pointer);
  - the address-field slicing functions.
- One sub-module, cache_way_store, instantiated 2**WAYS_BITS times. Each instance holds:
  - block RAM data, with a registered read indexed by set;
  - tag and valid registers, with combinational compare;
  - one write port driven in S_FILL.
- The top level contains the FSM, hit OR/way mux, victim logic, flush and counters.

## Test plan
Defaults apply throughout.
1. **Cold miss:** addr_in=0x00085 → addr_out_valid=1, addr_out=0x00021. Memory ready at once, data_in_valid after 2 cycles with words {W3,W2,W1,W0}. Then addr_in_ready=1, next cycle data_out=W1. miss_count=1, hit_count=1.
2. **Streaming hits:** 0x00084..0x00087 on consecutive cycles → addr_in_ready every cycle, data_out W0..W3 each one cycle later, hit_count+=4.
3. **Conflict:** fill 0x00004 (way0), 0x00084 (way1), then 0x00104 → evicts way0. Then 0x00084 hits and 0x00004 misses.
4. **Backpressure:** addr_out_ready low for 5 cycles → addr_out_valid held at 1, addr_out stable, addr_in_ready=0 throughout.
5. **Flush in S_WAIT:** the fill completes, the flush is applied in S_IDLE, a re-access of the same address misses, counters unchanged by the flush.
6. **Reset in S_WAIT:** all outputs 0 the next cycle, a later data_in_valid is ignored, and the line misses on access.
